// File: rtl/sm_pkg.sv
// Shared definitions for the stepper motion controller.
//   - command op codes carried on cmd_op
//   - controller state enum
//   - default start/stop period, also used as the pulse generator's NUM_PERIOD
package sm_pkg;

   // Start/stop period in clock cycles per step (25 kHz at a 50 MHz clock).
   localparam int unsigned PERIOD_START_DEF = 2000;

   localparam logic [1:0] OP_RUN   = 2'd0;  // continuous run until stop
   localparam logic [1:0] OP_RUN_N = 2'd1;  // run exactly cmd_count steps
   localparam logic [1:0] OP_RSVD  = 2'd2;  // accepted, ignored
   localparam logic [1:0] OP_AUTO  = 2'd3;  // fixed period, no ramp

   typedef enum logic [2:0] {
      StIdle,
      StAccel,
      StCruise,
      StDecel,
      StAuto,
      StDone
   } sm_state_e;

endpackage

// File: rtl/sm_step_edge.sv
// Step feedback edge detector.
// Corrects the generator pulse polarity and flags the rising edge of the
// corrected pulse for one cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   step_pulse    raw generator output, synchronous to clk
//   invert_pulse  polarity bit shared with the generator
//   step_edge     one-cycle flag: corrected pulse rose this cycle
module sm_step_edge (
   input  logic clk,
   input  logic rst,
   input  logic step_pulse,
   input  logic invert_pulse,
   output logic step_edge
);

   logic s;
   logic s_q;

   assign s = step_pulse ^ invert_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= 1'b0;
      end else begin
         s_q <= s;
      end
   end

   assign step_edge = s & ~s_q;

endmodule

// File: rtl/sm_motion_ctrl.sv
// Trapezoidal motion-profile controller for the stepper pulse generator.
// Accepts move commands, drives the generator enable/period with an
// accelerate / cruise / decelerate ramp and counts the step pulses fed back
// from the generator so counted moves end exactly on count.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op                   RUN, RUN_N, reserved, AUTO
//   cmd_period               target period (clamped on accept)
//   cmd_count                step count for RUN_N
//   stop                     level request for a controlled stop
//   invert_pulse, step_pulse generator polarity and step feedback
//   drv_en_SM, period_n      generator enable and period
//   busy, done, pulse_cnt    status: not idle, end-of-move pulse, steps emitted
module sm_motion_ctrl
   import sm_pkg::*;
#(
   parameter int unsigned SIZE         = 16,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned PERIOD_START = PERIOD_START_DEF,
   parameter int unsigned PERIOD_MIN   = 8,
   parameter int unsigned ACCEL_STEP   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [SIZE-1:0]  cmd_period,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             stop,
   input  logic             invert_pulse,
   input  logic             step_pulse,
   output logic             drv_en_SM,
   output logic [SIZE-1:0]  period_n,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   localparam logic [SIZE-1:0]  P_START = SIZE'(PERIOD_START);
   localparam logic [SIZE-1:0]  P_MIN   = SIZE'(PERIOD_MIN);
   localparam logic [SIZE:0]    P_STEP  = (SIZE+1)'(ACCEL_STEP);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [SIZE-1:0] clamp_period(input logic [SIZE-1:0] p);
      if (p < P_MIN) begin
         return P_MIN;
      end else if (p > P_START) begin
         return P_START;
      end
      return p;
   endfunction

   sm_state_e        state_q, state_d;
   logic [SIZE-1:0]  period_q, period_d;
   logic [SIZE-1:0]  target_q, target_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] ramp_q, ramp_d;
   logic [CNT_W-1:0] pulse_q, pulse_d;
   logic             run_n_q, run_n_d;
   // Set once stop is seen during a move; lets a RUN_N decel end on ramp exhaustion.
   logic             stop_seen_q, stop_seen_d;

   logic             step_edge;
   logic [SIZE-1:0]  cmd_tgt;
   logic [SIZE:0]    p_dec, p_inc;
   logic [SIZE-1:0]  acc_period, dec_period;
   logic [CNT_W-1:0] pulse_inc, ramp_inc, ramp_dec;

   sm_step_edge u_step_edge (
      .clk          (clk),
      .rst          (rst),
      .step_pulse   (step_pulse),
      .invert_pulse (invert_pulse),
      .step_edge    (step_edge)
   );

   assign cmd_tgt = clamp_period(cmd_period);

   // One extra bit so the subtraction cannot wrap before the clamp to target.
   always_comb begin
      p_dec      = {1'b0, period_q} - P_STEP;
      p_inc      = {1'b0, period_q} + P_STEP;
      acc_period = (p_dec[SIZE] || (p_dec[SIZE-1:0] < target_q)) ? target_q
                                                                  : p_dec[SIZE-1:0];
      dec_period = (p_inc > {1'b0, P_START}) ? P_START : p_inc[SIZE-1:0];
      pulse_inc  = (pulse_q == CNT_MAX) ? pulse_q : pulse_q + 1'b1;
      ramp_inc   = (ramp_q == CNT_MAX) ? ramp_q : ramp_q + 1'b1;
      ramp_dec   = (ramp_q == '0) ? ramp_q : ramp_q - 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      target_d    = target_q;
      count_d     = count_q;
      ramp_d      = ramp_q;
      pulse_d     = pulse_q;
      run_n_d     = run_n_q;
      stop_seen_d = stop_seen_q;

      unique case (state_q)
         StIdle: begin
            period_d = P_START;
            if (cmd_valid && cmd_ready) begin
               case (cmd_op)
                  OP_RUN, OP_RUN_N: begin
                     target_d    = cmd_tgt;
                     count_d     = cmd_count;
                     run_n_d     = (cmd_op == OP_RUN_N);
                     pulse_d     = '0;
                     ramp_d      = '0;
                     stop_seen_d = 1'b0;
                     if ((cmd_op == OP_RUN_N) && (cmd_count == '0)) begin
                        state_d = StDone;
                     end else if (cmd_tgt == P_START) begin
                        state_d = StCruise;
                     end else begin
                        state_d = StAccel;
                     end
                  end
                  OP_AUTO: begin
                     target_d    = cmd_tgt;
                     period_d    = cmd_tgt;
                     run_n_d     = 1'b0;
                     pulse_d     = '0;
                     ramp_d      = '0;
                     stop_seen_d = 1'b0;
                     state_d     = StAuto;
                  end
                  default: ;
               endcase
            end
         end

         StAccel, StCruise, StDecel: begin
            // Edge update first; stop and count transitions see the updated values.
            if (step_edge) begin
               pulse_d = pulse_inc;
               if (state_q == StAccel) begin
                  period_d = acc_period;
                  ramp_d   = ramp_inc;
                  if (acc_period == target_q) begin
                     state_d = StCruise;
                  end
               end else if (state_q == StDecel) begin
                  period_d = dec_period;
                  ramp_d   = ramp_dec;
               end
            end
            if (stop) begin
               stop_seen_d = 1'b1;
            end
            if (run_n_q && step_edge && (pulse_d == count_q)) begin
               state_d = StDone;
            end else if (state_q == StDecel) begin
               if ((!run_n_q || stop_seen_d) && (ramp_d == '0)) begin
                  state_d = StDone;
               end
            end else if (stop ||
                         (run_n_q && step_edge && ((count_q - pulse_d) <= ramp_d))) begin
               state_d = StDecel;
            end
         end

         StAuto: begin
            if (step_edge) begin
               pulse_d = pulse_inc;
            end
            if (stop) begin
               state_d = StDone;
            end
         end

         StDone: begin
            state_d  = StIdle;
            period_d = P_START;
         end

         default: begin
            state_d  = StIdle;
            period_d = P_START;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         period_q    <= P_START;
         target_q    <= P_START;
         count_q     <= '0;
         ramp_q      <= '0;
         pulse_q     <= '0;
         run_n_q     <= 1'b0;
         stop_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         target_q    <= target_d;
         count_q     <= count_d;
         ramp_q      <= ramp_d;
         pulse_q     <= pulse_d;
         run_n_q     <= run_n_d;
         stop_seen_q <= stop_seen_d;
      end
   end

   always_comb begin
      cmd_ready = (state_q == StIdle);
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      drv_en_SM = (state_q == StAccel) || (state_q == StCruise) ||
                  (state_q == StDecel) || (state_q == StAuto);
      period_n  = period_q;
      pulse_cnt = pulse_q;
   end

endmodule

// File: doc/sm_motion_ctrl.md
# sm_motion_ctrl

Motion-profile controller that sits directly upstream of the stepper pulse generator. It accepts move commands and drives the generator's enable and period inputs with a trapezoidal ramp: accelerate, cruise, decelerate. It counts the generated step pulses fed back from the generator, so that N-step moves end exactly on count and at the slow start period.

## Interface
- SIZE, 16, width of period values (clock cycles per step)
- CNT_W, 16, width of step counters
- PERIOD_START, 2000, start/stop period (25 kHz at 50 MHz clk)
- PERIOD_MIN, 8, lowest legal target period
- ACCEL_STEP, 16, period change per emitted step while ramping
- clk  in  1  50 MHz clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  high exactly when state is IDLE; reset value 1 after the rst cycle
- cmd_op  in  2  0 RUN (continuous), 1 RUN_N, 2 reserved (accepted, no effect), 3 AUTO (no ramp)
- cmd_period  in  SIZE  target period
- cmd_count  in  CNT_W  step count for RUN_N
- stop  in  1  level; requests controlled stop
- invert_pulse  in  1  same polarity bit as given to the generator
- step_pulse  in  1  generator output, synchronous to clk
- drv_en_SM  out  1  generator enable; reset 0
- period_n  out  SIZE  period to generator; reset PERIOD_START
- busy  out  1  state is not IDLE; reset 0
- done  out  1  one-cycle pulse at end of a move; reset 0
- pulse_cnt  out  CNT_W  steps emitted in the current move; reset 0, cleared on accept

## Operation
- Target clamp on accept: below PERIOD_MIN becomes PERIOD_MIN; above PERIOD_START becomes PERIOD_START.
- Step edge: s = step_pulse ^ invert_pulse, s_q registered, edge = s & ~s_q. s_q resets to 0.
- On each edge: pulse_cnt++ (saturating). Period/ramp updates below happen in the same cycle.
- States: IDLE, ACCEL, CRUISE, DECEL, AUTO, DONE.
- IDLE: drv_en_SM=0, period_n=PERIOD_START. A command is accepted when cmd_valid & cmd_ready.
  - RUN goes to ACCEL.
  - RUN_N with count 0 goes to DONE. RUN_N with count > 0 goes to ACCEL.
  - AUTO goes to AUTO. Op 2 stays in IDLE.
  - stop in IDLE is ignored.
- ACCEL, on each edge:
  - period_n = max(period_n - ACCEL_STEP, target); ramp_cnt++.
  - When period_n equals target, go to CRUISE.
  - If target == PERIOD_START at accept, go straight from accept to CRUISE.
- CRUISE: period_n is held.
- DECEL, on each edge:
  - period_n = min(period_n + ACCEL_STEP, PERIOD_START); ramp_cnt-- (floor 0).
- RUN_N rules, evaluated after each edge update:
  - pulse_cnt == count goes to DONE (highest priority).
  - Otherwise (count - pulse_cnt) <= ramp_cnt in ACCEL or CRUISE goes to DECEL.
- RUN, or stop during RUN_N:
  - stop in ACCEL or CRUISE goes to DECEL.
  - In DECEL, ramp_cnt == 0 goes to DONE.
  - A stop-initiated DECEL in RUN_N still ends early if the count is reached.
- AUTO: period_n = clamped cmd_period latched at accept, drv_en_SM=1, no ramp. stop goes to DONE directly.
- DONE: drv_en_SM=0, done=1 for one cycle, then IDLE. pulse_cnt holds until the next accept.
- rst in any state forces reset values next cycle. A move in progress is abandoned and no done is issued.

## Timing
- Accept at cycle T: drv_en_SM=1, period_n=PERIOD_START (AUTO: clamped target), busy=1, cmd_ready=0 at T+1.
- Edge sampled at cycle T: pulse_cnt, period_n and the state update are visible at T+1.
- Terminal edge at cycle T: state is DONE at T+1, so drv_en_SM=0 and done=1 at T+1. At T+2 the state is IDLE and cmd_ready=1.
- stop sampled high at T: DECEL at T+1; in AUTO, done=1 at T+1.
- An edge and stop in the same cycle: the edge update applies first, then the stop transition.

## Structure
- Shared package sm_pkg holds:
  - the op codes (OP_RUN, OP_RUN_N, OP_AUTO);
  - the state enum;
  - the PERIOD_START default (2000), shared with the pulse generator's NUM_PERIOD.
- One sub-module: sm_step_edge (polarity correction and rising-edge detect, output edge).
- Ramp arithmetic is done at SIZE+1 bits to avoid underflow before the max/min clamp.

## Test plan
- RUN_N count=10, target=1900, ACCEL_STEP=16 -> period_n 2000,1984,...; DECEL entered when remaining <= ramp_cnt; done pulse after the 10th edge; pulse_cnt=10; final period_n=PERIOD_START.
- RUN target=1968, 3 accel edges then stop -> CRUISE at 1968; DECEL ramps to 2000 after ramp_cnt reaches 0; then done.
- RUN_N count=0 -> done one cycle after accept; drv_en_SM never asserted.
- AUTO cmd_period=3 -> period_n=PERIOD_MIN (8), drv_en_SM=1; stop -> done next cycle.
- invert_pulse=1 with an inverted step train -> same pulse_cnt as the non-inverted run.
- rst mid-CRUISE -> next cycle drv_en_SM=0, period_n=2000, pulse_cnt=0, no done.
